// File: rtl/rf_param_pkg.sv
// Shared register-file constants, also imported by the MIPS control decoder.
package rf_param_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int DEPTH_DEFAULT = 32;
    localparam int REG_ZERO      = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending scoreboard with incrementally maintained pending count
// and read-port busy flags for RAW hazard detection in decode.
module rf_scoreboard
    import rf_param_pkg::*;
#(
    parameter  int DEPTH  = DEPTH_DEFAULT,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [AW-1:0] ra,
    input  logic [AW-1:0] rb,
    input  logic          iss_en,
    input  logic [AW-1:0] iss_rd,
    output logic          ra_busy,
    output logic          rb_busy,
    output logic [AW:0]   pend_cnt
);

    logic [DEPTH-1:0] r_pending;
    logic [AW:0]      r_cnt;
    logic [DEPTH-1:0] w_next;
    logic             w_set;
    logic             w_clr;
    logic             w_inc;
    logic             w_dec;
    logic             w_byp;

    assign w_byp = (BYPASS != 0);
    assign w_set = iss_en && (iss_rd != AW'(REG_ZERO));
    assign w_clr = we && (wa != AW'(REG_ZERO));

    // Next pending vector and count delta; issue is applied after the clear so it wins on a shared address
    always_comb begin
        w_next = r_pending;
        if (w_clr)
            w_next[wa] = 1'b0;
        if (w_set)
            w_next[iss_rd] = 1'b1;
        w_inc = w_set && !r_pending[iss_rd];
        w_dec = w_clr && r_pending[wa] && !(w_set && (iss_rd == wa));
    end

    // Scoreboard state with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
            r_cnt     <= '0;
        end else begin
            r_pending <= w_next;
            r_cnt     <= r_cnt + (AW+1)'(w_inc) - (AW+1)'(w_dec);
        end
    end

    // Busy flags; with bypass a same-cycle write to the read register resolves the hazard
    always_comb begin
        ra_busy = (ra != AW'(REG_ZERO)) && r_pending[ra] && !(w_byp && we && (wa == ra));
        rb_busy = (rb != AW'(REG_ZERO)) && r_pending[rb] && !(w_byp && we && (wa == rb));
    end

    assign pend_cnt = r_cnt;

endmodule

// File: rtl/rf_param.sv
// Parametrised 2R/1W register file with asynchronous clear, optional
// write-to-read bypass and a pending-write scoreboard. Register 0 reads zero.
module rf_param
    import rf_param_pkg::*;
#(
    parameter  int WIDTH  = WIDTH_DEFAULT,
    parameter  int DEPTH  = DEPTH_DEFAULT,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    ra,
    input  logic [AW-1:0]    rb,
    output logic [WIDTH-1:0] da,
    output logic [WIDTH-1:0] db,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_rd,
    output logic             ra_busy,
    output logic             rb_busy,
    output logic [AW:0]      pend_cnt
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_byp;

    assign w_byp = (BYPASS != 0);

    // Storage array: writes to register 0 are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (we && (wa != AW'(REG_ZERO))) begin
            r_mem[wa] <= wd;
        end
    end

    // Read muxing: zero register first, then same-cycle bypass, then array
    always_comb begin
        if (ra == AW'(REG_ZERO))
            da = '0;
        else if (w_byp && we && (wa == ra))
            da = wd;
        else
            da = r_mem[ra];

        if (rb == AW'(REG_ZERO))
            db = '0;
        else if (w_byp && we && (wa == rb))
            db = wd;
        else
            db = r_mem[rb];
    end

    rf_scoreboard #(
        .DEPTH  (DEPTH),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .wa       (wa),
        .ra       (ra),
        .rb       (rb),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .ra_busy  (ra_busy),
        .rb_busy  (rb_busy),
        .pend_cnt (pend_cnt)
    );

endmodule

// File: tb/tb_rf_param.sv
// Scoreboard bench for rf_param: three instances (32x32 with and without
// bypass, 16x8 with bypass). Stimulus pushes expectations, a negedge monitor
// pops and compares them against the live outputs.
module tb_rf_param;

    localparam int SIG_DA = 0, SIG_DB = 1, SIG_RAB = 2, SIG_RBB = 3, SIG_CNT = 4;
    localparam int DUT_A = 0, DUT_B = 1, DUT_C = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Shared stimulus for the two 32x32 instances
    logic        we = 0, iss_en = 0;
    logic [4:0]  wa = 0, ra = 0, rb = 0, iss_rd = 0;
    logic [31:0] wd = 0;
    logic [31:0] da_a, db_a, da_b, db_b;
    logic        rab_a, rbb_a, rab_b, rbb_b;
    logic [5:0]  cnt_a, cnt_b;

    // Stimulus for the 16x8 instance
    logic        we_c = 0, iss_en_c = 0;
    logic [2:0]  wa_c = 0, ra_c = 0, rb_c = 0, iss_rd_c = 0;
    logic [15:0] wd_c = 0;
    logic [15:0] da_c, db_c;
    logic        rab_c, rbb_c;
    logic [3:0]  cnt_c;

    typedef struct {
        int          dut;
        int          sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rf_param #(.WIDTH(32), .DEPTH(32), .BYPASS(1)) u_a (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rb(rb),
        .da(da_a), .db(db_a), .iss_en(iss_en), .iss_rd(iss_rd),
        .ra_busy(rab_a), .rb_busy(rbb_a), .pend_cnt(cnt_a)
    );

    rf_param #(.WIDTH(32), .DEPTH(32), .BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rb(rb),
        .da(da_b), .db(db_b), .iss_en(iss_en), .iss_rd(iss_rd),
        .ra_busy(rab_b), .rb_busy(rbb_b), .pend_cnt(cnt_b)
    );

    rf_param #(.WIDTH(16), .DEPTH(8), .BYPASS(1)) u_c (
        .clk(clk), .rst(rst), .we(we_c), .wa(wa_c), .wd(wd_c), .ra(ra_c), .rb(rb_c),
        .da(da_c), .db(db_c), .iss_en(iss_en_c), .iss_rd(iss_rd_c),
        .ra_busy(rab_c), .rb_busy(rbb_c), .pend_cnt(cnt_c)
    );

    function automatic logic [31:0] get_out(input int dut, input int sig);
        logic [31:0] v;
        v = '0;
        case (dut)
            DUT_A: case (sig)
                SIG_DA:  v = da_a;
                SIG_DB:  v = db_a;
                SIG_RAB: v = {31'd0, rab_a};
                SIG_RBB: v = {31'd0, rbb_a};
                default: v = {26'd0, cnt_a};
            endcase
            DUT_B: case (sig)
                SIG_DA:  v = da_b;
                SIG_DB:  v = db_b;
                SIG_RAB: v = {31'd0, rab_b};
                SIG_RBB: v = {31'd0, rbb_b};
                default: v = {26'd0, cnt_b};
            endcase
            default: case (sig)
                SIG_DA:  v = {16'd0, da_c};
                SIG_DB:  v = {16'd0, db_c};
                SIG_RAB: v = {31'd0, rab_c};
                SIG_RBB: v = {31'd0, rbb_c};
                default: v = {28'd0, cnt_c};
            endcase
        endcase
        return v;
    endfunction

    task automatic expect_out(input int dut, input int sig, input logic [31:0] val, input string name);
        exp_t x;
        x.dut  = dut;
        x.sig  = sig;
        x.val  = val;
        x.name = name;
        sb_q.push_back(x);
    endtask

    // Advance to just after the next rising edge, where inputs are driven
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are combinational, so they are compared mid-cycle
    always @(negedge clk) begin
        while (sb_q.size() != 0) begin
            logic [31:0] act;
            e   = sb_q.pop_front();
            act = get_out(e.dut, e.sig);
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.val);
            end
        end
    end

    initial begin
        // Reset state
        step();
        expect_out(DUT_A, SIG_DA,  0, "rst_da_a");
        expect_out(DUT_A, SIG_DB,  0, "rst_db_a");
        expect_out(DUT_A, SIG_RAB, 0, "rst_rab_a");
        expect_out(DUT_A, SIG_RBB, 0, "rst_rbb_a");
        expect_out(DUT_A, SIG_CNT, 0, "rst_cnt_a");
        expect_out(DUT_B, SIG_CNT, 0, "rst_cnt_b");
        expect_out(DUT_C, SIG_CNT, 0, "rst_cnt_c");

        // Bypass: same-cycle write forwarded only on the BYPASS=1 instance
        step();
        rst = 0; we = 1; wa = 7; wd = 32'h1234; ra = 7; rb = 0;
        expect_out(DUT_A, SIG_DA, 32'h1234, "byp_da_a");
        expect_out(DUT_B, SIG_DA, 32'h0,    "nobyp_da_b");
        expect_out(DUT_A, SIG_DB, 32'h0,    "byp_db_r0");
        step();
        we = 0;
        expect_out(DUT_A, SIG_DA, 32'h1234, "after_da_a");
        expect_out(DUT_B, SIG_DA, 32'h1234, "after_da_b");

        // Zero register: write ignored, never forwarded, never pending
        step();
        we = 1; wa = 0; wd = 32'hFFFF_FFFF; ra = 0;
        expect_out(DUT_A, SIG_DA, 0, "r0_byp_da");
        step();
        we = 0; iss_en = 1; iss_rd = 0;
        expect_out(DUT_A, SIG_DA, 0, "r0_da_a");
        expect_out(DUT_B, SIG_DA, 0, "r0_da_b");
        step();
        iss_en = 0;
        expect_out(DUT_A, SIG_CNT, 0, "r0_iss_cnt");
        expect_out(DUT_A, SIG_RAB, 0, "r0_rab");

        // Reset clear mid-operation: r5 written, r8 issued, then async reset pulse
        step();
        we = 1; wa = 5; wd = 32'hDEAD_BEEF; iss_en = 1; iss_rd = 8;
        step();
        we = 0; iss_en = 0; ra = 5; rb = 7;
        expect_out(DUT_A, SIG_DA,  32'hDEAD_BEEF, "pre_rst_da");
        expect_out(DUT_A, SIG_CNT, 1,             "pre_rst_cnt");
        step();
        rst = 1;
        #2;
        rst = 0;
        expect_out(DUT_A, SIG_DA,  0, "rst_clear_da_a");
        expect_out(DUT_B, SIG_DA,  0, "rst_clear_da_b");
        expect_out(DUT_A, SIG_DB,  0, "rst_clear_r7");
        expect_out(DUT_A, SIG_CNT, 0, "rst_clear_cnt");

        // Scoreboard: issue r3 then r9, then write r3
        step();
        iss_en = 1; iss_rd = 3; ra = 3; rb = 9;
        expect_out(DUT_A, SIG_RAB, 0, "sb_r3_not_yet");
        step();
        iss_rd = 9;
        expect_out(DUT_A, SIG_RAB, 1, "sb_r3_busy");
        expect_out(DUT_A, SIG_CNT, 1, "sb_cnt1");
        step();
        iss_en = 0; we = 1; wa = 3; wd = 32'h33;
        expect_out(DUT_A, SIG_CNT, 2, "sb_cnt2");
        expect_out(DUT_A, SIG_RAB, 0, "sb_r3_wr_byp");
        expect_out(DUT_B, SIG_RAB, 1, "sb_r3_wr_nobyp");
        expect_out(DUT_B, SIG_RBB, 1, "sb_r9_busy");
        step();
        we = 0;
        expect_out(DUT_A, SIG_CNT, 1,     "sb_cnt_after_wr");
        expect_out(DUT_A, SIG_RAB, 0,     "sb_r3_clear_a");
        expect_out(DUT_B, SIG_RAB, 0,     "sb_r3_clear_b");
        expect_out(DUT_A, SIG_RBB, 1,     "sb_r9_still");
        expect_out(DUT_B, SIG_DA,  32'h33, "sb_r3_data");

        // Back-to-back producer on r4: issue wins over write
        step();
        iss_en = 1; iss_rd = 4;
        step();
        we = 1; wa = 4; wd = 32'h44; ra = 4;
        expect_out(DUT_A, SIG_CNT, 2, "b2b_cnt_before");
        expect_out(DUT_A, SIG_RAB, 0, "b2b_rab_byp");
        expect_out(DUT_B, SIG_RAB, 1, "b2b_rab_nobyp");
        step();
        iss_en = 0; we = 0;
        expect_out(DUT_A, SIG_CNT, 2,      "b2b_cnt_same");
        expect_out(DUT_B, SIG_RAB, 1,      "b2b_r4_pending");
        expect_out(DUT_B, SIG_DA,  32'h44, "b2b_mem4");

        // Different addresses: issue r2 while writing pending r6
        step();
        iss_en = 1; iss_rd = 6;
        step();
        iss_rd = 2; we = 1; wa = 6; wd = 32'h66; ra = 2; rb = 6;
        expect_out(DUT_A, SIG_CNT, 3, "diff_cnt_before");
        step();
        iss_en = 0; we = 0;
        expect_out(DUT_A, SIG_CNT, 3,      "diff_cnt_same");
        expect_out(DUT_A, SIG_RAB, 1,      "diff_r2_pending");
        expect_out(DUT_A, SIG_RBB, 0,      "diff_r6_clear");
        expect_out(DUT_B, SIG_DB,  32'h66, "diff_r6_data");

        // Same address, not pending: write lands and register becomes pending
        step();
        iss_en = 1; iss_rd = 10; we = 1; wa = 10; wd = 32'hA; ra = 10;
        step();
        iss_en = 0; we = 0;
        expect_out(DUT_A, SIG_CNT, 4,     "same_np_cnt");
        expect_out(DUT_A, SIG_RAB, 1,     "same_np_busy");
        expect_out(DUT_B, SIG_DA,  32'hA, "same_np_data");

        // Write to a non-pending register leaves the count alone
        step();
        we = 1; wa = 11; wd = 32'hB;
        step();
        we = 0;
        expect_out(DUT_A, SIG_CNT, 4, "wr_np_cnt");

        // 16x8 instance: fill the scoreboard, then drain it by writes
        for (int i = 1; i <= 7; i++) begin
            step();
            iss_en_c = 1; iss_rd_c = 3'(i);
            expect_out(DUT_C, SIG_CNT, 32'(i - 1), "c_fill_cnt");
        end
        step();
        iss_en_c = 0;
        expect_out(DUT_C, SIG_CNT, 7, "c_full_cnt");
        for (int i = 1; i <= 7; i++) begin
            step();
            we_c = 1; wa_c = 3'(i); wd_c = 16'(i * 16'h111);
            expect_out(DUT_C, SIG_CNT, 32'(8 - i), "c_drain_cnt");
        end
        step();
        we_c = 0; ra_c = 7; rb_c = 1;
        expect_out(DUT_C, SIG_CNT, 0,        "c_empty_cnt");
        expect_out(DUT_C, SIG_DA,  16'h777,  "c_r7_data");
        expect_out(DUT_C, SIG_DB,  16'h111,  "c_r1_data");
        expect_out(DUT_C, SIG_RAB, 0,        "c_r7_idle");

        // Bounded drain of outstanding expectations
        begin
            int budget;
            budget = 10;
            while (sb_q.size() != 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            if (sb_q.size() != 0) begin
                errors++;
                $display("FAIL drain: got %0d pending expected 0", sb_q.size());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_param.md
# rf_param

Parametrised two-read/one-write register file for the single-cycle and upcoming pipelined MIPS datapaths. It generalises the 32×32 register file in three ways: width and depth are parameters, the array has an asynchronous clear, and an optional write-to-read bypass can be enabled. It adds a per-register pending scoreboard with an outstanding-write counter, so a pipelined decode stage can detect read-after-write hazards. Register 0 always reads as zero and is never pending.

## Interface
- WIDTH, 32, data width in bits
- DEPTH, 32, number of registers; power of two, ≥ 2
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads return array contents only
- AW (localparam), $clog2(DEPTH), register address width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- we  in  1  write enable (RegWrite)
- wa  in  AW  write address
- wd  in  WIDTH  write data
- ra  in  AW  read address A
- rb  in  AW  read address B
- da  out  WIDTH  read data A, combinational
- db  out  WIDTH  read data B, combinational
- iss_en  in  1  issue: marks register iss_rd pending
- iss_rd  in  AW  destination register of the issued instruction
- ra_busy  out  1  register ra has an outstanding write
- rb_busy  out  1  register rb has an outstanding write
- pend_cnt  out  AW+1  number of pending registers

## Operation
- **Reset.** rst=1 asynchronously clears every array entry to 0, every pending bit to 0 and pend_cnt to 0. Reset asserted mid-operation discards all pending state immediately. No write or issue takes effect in a cycle where rst is high at the edge.
- **Write.** On a clk edge with we=1 and wa≠0, mem[wa] is loaded with wd. A write to address 0 is ignored.
- **Read.** da = 0 if ra=0. Otherwise, if BYPASS=1 and we=1 and wa=ra, da = wd. Otherwise da = mem[ra]. db follows the same rule using rb.
- **Scoreboard set.** iss_en=1 with iss_rd≠0 sets pending[iss_rd] at the edge. Issuing a register that is already pending leaves it pending and leaves the count unchanged.
- **Scoreboard clear.** we=1 with wa≠0 clears pending[wa] at the edge. Writing a register that is not pending is legal, and the scoreboard does not change.
- **Simultaneous events:**
  - If iss_rd = wa and the register is nonzero and pending, issue wins: it stays pending and pend_cnt is unchanged. This is a back-to-back producer.
  - If iss_rd = wa and the register is not pending, the write lands and the register becomes pending; pend_cnt increments by 1.
  - If the addresses differ, both updates apply; pend_cnt changes by +1, −1 or 0 to match the new bit count.
- **pend_cnt** always equals the popcount of pending[] and never exceeds DEPTH−1. It is maintained incrementally, not recomputed by popcount.
- **Busy outputs:**
  - ra_busy = pending[ra] when BYPASS=0.
  - ra_busy = pending[ra] & ~(we & wa=ra) when BYPASS=1.
  - ra_busy is 0 whenever ra=0. rb_busy follows the same rules using rb.

## Timing
- Read latency is zero: da, db, ra_busy and rb_busy are combinational from addresses, the array, pending[], and the write port when BYPASS=1.
- A write is visible through the array on the cycle after the edge. With BYPASS=1 it is also visible in the same cycle.
- An issue is visible on ra_busy/rb_busy and pend_cnt on the cycle after the edge.
- No handshake and no stalls: the port accepts one write and one issue every cycle.
- Reset values: da = 0, db = 0, ra_busy = 0, rb_busy = 0, pend_cnt = 0.

## Structure
- The shared package holds WIDTH_DEFAULT=32, DEPTH_DEFAULT=32 and the REG_ZERO=0 constant; the MIPS control decoder imports the same constants.
- One sub-module: **rf_scoreboard**, which owns pending[], pend_cnt and the busy logic.
- The top level holds the storage array and the read/bypass muxing.

## Test plan
- **Reset clear:** write 0xDEADBEEF to r5, then pulse rst between clock edges → da reads 0 at r5 immediately, before the next edge; pend_cnt = 0.
- **Bypass:** BYPASS=1, we=1, wa=7, wd=0x1234, ra=7 in the same cycle → da = 0x1234. With BYPASS=0, da shows the old value (0) until the next cycle.
- **Zero register:** write 0xFFFFFFFF to r0, then ra=0 → da = 0. iss_rd=0 → pend_cnt stays 0 and ra_busy = 0.
- **Scoreboard:**
  - Issue r3, then next cycle issue r9 → pend_cnt = 2 and ra_busy=1 for ra=3.
  - Then write r3 → pend_cnt = 1 and ra_busy = 0 for ra=3.
- **Simultaneous events:**
  - r4 pending, then iss_rd=4 and we=1 with wa=4 in the same cycle → r4 stays pending, pend_cnt unchanged, mem[4] updated.
  - iss_rd=2 and wa=6 (r6 pending) in the same cycle → pend_cnt unchanged, r2 pending, r6 clear.
- **Parametrisation:** with WIDTH=16, DEPTH=8, issue r1–r7 → pend_cnt = 7. Writing all seven registers returns pend_cnt to 0.
